// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM state values and master indices.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb_pick.sv
// Next-grant selector for wb_arbiter_2m; holds the whole priority policy.
// WB_ARB_FIXED_PRIO_EN: m0 always wins a tie in IDLE and `last` is ignored.
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  arb_state_t state,
  output arb_state_t state_nxt
);

  logic tie_to_m1;

`ifdef WB_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign tie_to_m1   = 1'b0;
`else
  assign tie_to_m1 = (last == M0);
`endif

  // The holder is never pre-empted; on release the other requester takes over directly.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) state_nxt = tie_to_m1 ? GNT1 : GNT0;
        else if (req[0])      state_nxt = GNT0;
        else if (req[1])      state_nxt = GNT1;
        else                  state_nxt = IDLE;
      end
      GNT0: begin
        if (req[0])      state_nxt = GNT0;
        else if (req[1]) state_nxt = GNT1;
        else             state_nxt = IDLE;
      end
      GNT1: begin
        if (req[1])      state_nxt = GNT1;
        else if (req[0]) state_nxt = GNT0;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave classic Wishbone arbiter; grant held while the owner keeps cyc high.
// Build option WB_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
//
// state | meaning
// IDLE  | no grant, slave bus parked at zero
// GNT0  | m0 owns the slave bus
// GNT1  | m1 owns the slave bus
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic [addr_width-1:0]   m0_wb_adr,
  input  logic [data_width-1:0]   m0_wb_datwr,
  output logic [data_width-1:0]   m0_wb_datrd,
  input  logic                    m0_wb_we,
  input  logic                    m0_wb_stb,
  input  logic                    m0_wb_cyc,
  input  logic [strobe_width-1:0] m0_wb_sel,
  output logic                    m0_wb_ack,

  input  logic [addr_width-1:0]   m1_wb_adr,
  input  logic [data_width-1:0]   m1_wb_datwr,
  output logic [data_width-1:0]   m1_wb_datrd,
  input  logic                    m1_wb_we,
  input  logic                    m1_wb_stb,
  input  logic                    m1_wb_cyc,
  input  logic [strobe_width-1:0] m1_wb_sel,
  output logic                    m1_wb_ack,

  output logic [addr_width-1:0]   s_wb_adr,
  output logic [data_width-1:0]   s_wb_datwr,
  input  logic [data_width-1:0]   s_wb_datrd,
  output logic                    s_wb_we,
  output logic                    s_wb_stb,
  output logic                    s_wb_cyc,
  output logic [strobe_width-1:0] s_wb_sel,
  input  logic                    s_wb_ack
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;

  wb_arb_pick u_pick (
    .req       ({m1_wb_cyc, m0_wb_cyc}),
    .last      (last),
    .state     (state),
    .state_nxt (state_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  assign last = M1;
`else
  always_ff @(posedge clock) begin
    if (reset)                  last <= M1;
    else if (state_nxt == GNT0) last <= M0;
    else if (state_nxt == GNT1) last <= M1;
  end
`endif

  // Reset gates the bus immediately so a transfer in flight is abandoned in the same cycle.
  always_comb begin
    s_wb_adr   = '0;
    s_wb_datwr = '0;
    s_wb_we    = 1'b0;
    s_wb_stb   = 1'b0;
    s_wb_cyc   = 1'b0;
    s_wb_sel   = '0;
    m0_wb_ack  = 1'b0;
    m1_wb_ack  = 1'b0;
    if (!reset) begin
      case (state)
        GNT0: begin
          s_wb_adr   = m0_wb_adr;
          s_wb_datwr = m0_wb_datwr;
          s_wb_we    = m0_wb_we;
          s_wb_stb   = m0_wb_stb;
          s_wb_cyc   = m0_wb_cyc;
          s_wb_sel   = m0_wb_sel;
          m0_wb_ack  = s_wb_ack;
        end
        GNT1: begin
          s_wb_adr   = m1_wb_adr;
          s_wb_datwr = m1_wb_datwr;
          s_wb_we    = m1_wb_we;
          s_wb_stb   = m1_wb_stb;
          s_wb_cyc   = m1_wb_cyc;
          s_wb_sel   = m1_wb_sel;
          m1_wb_ack  = s_wb_ack;
        end
        default: ;
      endcase
    end
  end

  assign m0_wb_datrd = s_wb_datrd;
  assign m1_wb_datrd = s_wb_datrd;

endmodule
